alu_issue: RTL and testbench
============================

# alu_issue

Registered issue stage that drives the ALU's `ALUCtrl`, `BusA` and `BusB` inputs. It decodes a MIPS instruction word plus the two register-file read values into the 4-bit ALU operation code and the final operands: shift amount, extended immediate or register. Results are presented through a valid/ready handshake with a one-entry skid buffer. It sits between register read and the ALU, so the ALU stays purely combinational.

## Interface
Parameters:
- none (widths fixed: 32-bit datapath, 4-bit ALU control)

Ports:
- `CLK` in 1: clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `InValid` in 1: upstream holds a valid instruction and operands.
- `InReady` out 1: block accepts on the cycle `InValid & InReady` is high.
- `Instruction` in 32: MIPS instruction word.
- `RegA` in 32: rs read value.
- `RegB` in 32: rt read value.
- `OutValid` out 1: `ALUCtrl`/`BusA`/`BusB`/`Illegal` are valid.
- `OutReady` in 1: downstream consumes on `OutValid & OutReady`.
- `ALUCtrl` out 4: ALU operation code.
- `BusA` out 32: ALU operand A.
- `BusB` out 32: ALU operand B.
- `Illegal` out 1: unsupported opcode/funct; `ALUCtrl`=0, `BusA`=`BusB`=0.

## Operation
- Codes: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, ADDU=8, SUBU=9, XOR=A, SLTU=B, NOR=C, SRA=D, LUI=E.
- R-type (op 0x00), funct -> code:
  - 0x20/21/22/23 -> ADD/ADDU/SUB/SUBU.
  - 0x24/25/26/27 -> AND/OR/XOR/NOR.
  - 0x2A/2B -> SLT/SLTU.
  - `BusA`=`RegA`, `BusB`=`RegB`.
- Immediate shifts, funct 0x00/02/03 -> SLL/SRL/SRA:
  - `BusA`=`RegB`.
  - `BusB`={27'b0, shamt[10:6]}.
- Variable shifts, funct 0x04/06/07 -> SLL/SRL/SRA:
  - `BusA`=`RegB`.
  - `BusB`={27'b0, `RegA`[4:0]}.
  - Always mask to 5 bits; the ALU shifts by all 32 bits of `BusB`.
- I-type, `BusA`=`RegA`:
  - 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU, 0x23 lw ADD, 0x2B sw ADD: `BusB` = sign-extended imm.
  - 0x0C AND, 0x0D OR, 0x0E XOR: `BusB` = zero-extended imm.
  - 0x0F LUI: `BusB`={16'b0, imm}.
  - 0x04 beq, 0x05 bne: SUB with `BusB`=`RegB`.
- Any other opcode, or R-type funct not listed -> `Illegal`=1 with zeroed control and operands. The entry still flows through the handshake.
- Decode is combinational on the input side. It is captured into the output register on accept.

## Timing
- Latency: accept in cycle N -> `OutValid` at N+1.
- Throughput: 1 per cycle while `OutReady`=1.
- Reset: `OutValid`=0, `ALUCtrl`=0, `BusA`=0, `BusB`=0, `Illegal`=0.
  - With skid: skid empty, `InReady`=1 from the first cycle after reset.
  - Reset mid-transfer discards both the output and skid entries.
- Outputs are stable while `OutValid & ~OutReady`; they change only after a transfer.
- Output register loads when it is empty or being drained.
- Simultaneous accept and drain: the new entry replaces the drained one with no bubble.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - `InReady` is a flop, equal to the complement of skid-full.
  - An accept while the output is stalled goes to the skid entry.
  - A drain moves the skid entry to the output next cycle.
  - Once the skid is full, `InReady`=0 in the following cycle.
- `ALU_ISSUE_SKID_EN` undefined:
  - No skid storage.
  - `InReady` = `OutReady | ~OutValid`, a combinational path from `OutReady`.
  - Identical latency and ordering.

## Test plan
- Reset held 2 cycles -> all outputs 0, `OutValid`=0; with skid, `InReady`=1 the cycle after release.
- `addi` (op 08) with imm 0xFFFF, `RegA`=5, `OutReady`=1 -> next cycle `ALUCtrl`=2, `BusA`=5, `BusB`=0xFFFFFFFF.
- `sll` shamt=4, `RegB`=0x1; then `srav` with `RegA`=0x25, `RegB`=0x80000000:
  - first -> `ALUCtrl`=3, `BusA`=1, `BusB`=4.
  - second -> `ALUCtrl`=D, `BusB`=5.
- `ori` imm 0x8000 -> `BusB`=0x00008000. `lui` imm 0x1234 -> `ALUCtrl`=E, `BusB`=0x1234.
- op 0x3F -> `Illegal`=1, `ALUCtrl`=0, `BusA`=`BusB`=0.
- Back-to-back stream of 3 instructions with `OutReady` low for 3 cycles:
  - With skid: no loss or duplication, in-order delivery, `InReady` drops after the skid fills.
  - Without skid: `InReady` tracks `OutReady`.

Source files
------------

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - registered MIPS ALU issue stage with valid/ready handshake
// Optional one-entry skid buffer: define ALU_ISSUE_SKID_EN.
module alu_issue (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] Instruction,
   input  logic [31:0] RegA,
   input  logic [31:0] RegB,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [3:0]  ALUCtrl,
   output logic [31:0] BusA,
   output logic [31:0] BusB,
   output logic        Illegal
);

   localparam logic [3:0] C_AND  = 4'h0;
   localparam logic [3:0] C_OR   = 4'h1;
   localparam logic [3:0] C_ADD  = 4'h2;
   localparam logic [3:0] C_SLL  = 4'h3;
   localparam logic [3:0] C_SRL  = 4'h4;
   localparam logic [3:0] C_SUB  = 4'h6;
   localparam logic [3:0] C_SLT  = 4'h7;
   localparam logic [3:0] C_ADDU = 4'h8;
   localparam logic [3:0] C_SUBU = 4'h9;
   localparam logic [3:0] C_XOR  = 4'hA;
   localparam logic [3:0] C_SLTU = 4'hB;
   localparam logic [3:0] C_NOR  = 4'hC;
   localparam logic [3:0] C_SRA  = 4'hD;
   localparam logic [3:0] C_LUI  = 4'hE;

   // Operand-B source selection produced by the decoder
   typedef enum logic [2:0] {
      SEL_REG   = 3'd0,  // A=RegA, B=RegB
      SEL_SHAMT = 3'd1,  // A=RegB, B=shamt
      SEL_SHVAR = 3'd2,  // A=RegB, B=RegA[4:0]
      SEL_SEXT  = 3'd3,  // A=RegA, B=sign-extended imm
      SEL_ZEXT  = 3'd4   // A=RegA, B=zero-extended imm
   } sel_e;

   typedef struct packed {
      logic        ill;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } issue_t;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        unused_bits;

   assign op          = Instruction[31:26];
   assign funct       = Instruction[5:0];
   assign shamt       = Instruction[10:6];
   assign imm         = Instruction[15:0];
   assign unused_bits = ^Instruction[25:16];

   logic       hit;
   logic [3:0] code;
   sel_e       sel;
   issue_t     dec;

   // Opcode/funct table: operation code and operand routing
   always_comb begin
      hit  = 1'b1;
      code = C_AND;
      sel  = SEL_REG;
      case (op)
         6'h00: begin
            case (funct)
               6'h20: code = C_ADD;
               6'h21: code = C_ADDU;
               6'h22: code = C_SUB;
               6'h23: code = C_SUBU;
               6'h24: code = C_AND;
               6'h25: code = C_OR;
               6'h26: code = C_XOR;
               6'h27: code = C_NOR;
               6'h2A: code = C_SLT;
               6'h2B: code = C_SLTU;
               6'h00: begin code = C_SLL; sel = SEL_SHAMT; end
               6'h02: begin code = C_SRL; sel = SEL_SHAMT; end
               6'h03: begin code = C_SRA; sel = SEL_SHAMT; end
               6'h04: begin code = C_SLL; sel = SEL_SHVAR; end
               6'h06: begin code = C_SRL; sel = SEL_SHVAR; end
               6'h07: begin code = C_SRA; sel = SEL_SHVAR; end
               default: hit = 1'b0;
            endcase
         end
         6'h08, 6'h23, 6'h2B: begin code = C_ADD;  sel = SEL_SEXT; end
         6'h09:               begin code = C_ADDU; sel = SEL_SEXT; end
         6'h0A:               begin code = C_SLT;  sel = SEL_SEXT; end
         6'h0B:               begin code = C_SLTU; sel = SEL_SEXT; end
         6'h0C:               begin code = C_AND;  sel = SEL_ZEXT; end
         6'h0D:               begin code = C_OR;   sel = SEL_ZEXT; end
         6'h0E:               begin code = C_XOR;  sel = SEL_ZEXT; end
         6'h0F:               begin code = C_LUI;  sel = SEL_ZEXT; end
         6'h04, 6'h05:        begin code = C_SUB;  sel = SEL_REG;  end
         default:             hit = 1'b0;
      endcase
   end

   // Operand muxing; an illegal entry carries all-zero control and operands
   always_comb begin
      dec = '0;
      if (!hit) begin
         dec.ill = 1'b1;
      end else begin
         dec.ctrl = code;
         case (sel)
            SEL_SHAMT: begin dec.a = RegB; dec.b = {27'b0, shamt};     end
            SEL_SHVAR: begin dec.a = RegB; dec.b = {27'b0, RegA[4:0]}; end
            SEL_SEXT:  begin dec.a = RegA; dec.b = {{16{imm[15]}}, imm}; end
            SEL_ZEXT:  begin dec.a = RegA; dec.b = {16'b0, imm};       end
            default:   begin dec.a = RegA; dec.b = RegB;               end
         endcase
      end
   end

   logic   out_valid_q, out_valid_d;
   issue_t out_data_q,  out_data_d;
   logic   in_ready;
   logic   accept;
   logic   out_load;

`ifdef ALU_ISSUE_SKID_EN
   logic   skid_valid_q, skid_valid_d;
   issue_t skid_data_q,  skid_data_d;
   logic   in_ready_q,   in_ready_d;

   // Handshake: output register refills from the skid first to keep order
   always_comb begin
      in_ready     = in_ready_q;
      accept       = InValid & in_ready;
      out_load     = ~out_valid_q | OutReady;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (out_load) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) out_data_d = dec;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = dec;
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers; reset drops both held entries
   always_ff @(posedge CLK) begin
      if (Reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   // Handshake: accept whenever the output register is empty or draining
   always_comb begin
      in_ready    = OutReady | ~out_valid_q;
      accept      = InValid & in_ready;
      out_load    = in_ready;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (out_load) begin
         out_valid_d = accept;
         if (accept) out_data_d = dec;
      end
   end

   // State registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
`endif

   assign InReady  = in_ready;
   assign OutValid = out_valid_q;
   assign Illegal  = out_data_q.ill;
   assign ALUCtrl  = out_data_q.ctrl;
   assign BusA     = out_data_q.a;
   assign BusB     = out_data_q.b;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue against a table-driven model
module tb_alu_issue;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [31:0] Instruction;
   logic [31:0] RegA;
   logic [31:0] RegB;
   logic        OutValid;
   logic        OutReady;
   logic [3:0]  ALUCtrl;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic        Illegal;

   always #5 CLK = ~CLK;

   alu_issue dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .Instruction(Instruction), .RegA(RegA), .RegB(RegB),
      .OutValid(OutValid), .OutReady(OutReady), .ALUCtrl(ALUCtrl),
      .BusA(BusA), .BusB(BusB), .Illegal(Illegal)
   );

   typedef struct packed {
      logic        ill;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];

   // funct/opcode tables: code (-1 = unsupported) and operand kind
   int r_code[64];
   int r_kind[64];   // 0 reg/reg, 1 shamt shift, 2 variable shift
   int i_code[64];
   int i_kind[64];   // 0 sign-ext imm, 1 zero-ext imm, 2 RegB

   initial begin
      for (int i = 0; i < 64; i++) begin
         r_code[i] = -1; r_kind[i] = 0; i_code[i] = -1; i_kind[i] = 0;
      end
      r_code[32] = 2;  r_code[33] = 8;  r_code[34] = 6;  r_code[35] = 9;
      r_code[36] = 0;  r_code[37] = 1;  r_code[38] = 10; r_code[39] = 12;
      r_code[42] = 7;  r_code[43] = 11;
      r_code[0] = 3;  r_kind[0] = 1;  r_code[2] = 4;  r_kind[2] = 1;
      r_code[3] = 13; r_kind[3] = 1;  r_code[4] = 3;  r_kind[4] = 2;
      r_code[6] = 4;  r_kind[6] = 2;  r_code[7] = 13; r_kind[7] = 2;
      i_code[8] = 2;  i_code[9] = 8;  i_code[10] = 7; i_code[11] = 11;
      i_code[35] = 2; i_code[43] = 2;
      i_code[12] = 0; i_kind[12] = 1; i_code[13] = 1;  i_kind[13] = 1;
      i_code[14] = 10; i_kind[14] = 1; i_code[15] = 14; i_kind[15] = 1;
      i_code[4] = 6;  i_kind[4] = 2;  i_code[5] = 6;  i_kind[5] = 2;
   end

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   op;
      int   fn;
      int   imm;
      e   = '0;
      op  = int'(ins[31:26]);
      fn  = int'(ins[5:0]);
      imm = int'(ins[15:0]);
      if (op == 0) begin
         if (r_code[fn] < 0) e.ill = 1'b1;
         else begin
            e.ctrl = 4'(r_code[fn]);
            if (r_kind[fn] == 0)      begin e.a = a; e.b = b; end
            else if (r_kind[fn] == 1) begin e.a = b; e.b = 32'(int'(ins[10:6])); end
            else                      begin e.a = b; e.b = a % 32; end
         end
      end else if (i_code[op] < 0) begin
         e.ill = 1'b1;
      end else begin
         e.ctrl = 4'(i_code[op]);
         e.a    = a;
         if (i_kind[op] == 0)      e.b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
         else if (i_kind[op] == 1) e.b = 32'(imm);
         else                      e.b = b;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] ra,
                        input logic [31:0] rb, input logic ordy, output logic acc);
      logic exp_ir;
      logic drn;
      @(negedge CLK);
      InValid = iv; Instruction = ins; RegA = ra; RegB = rb; OutReady = ordy;
      #1;
`ifdef ALU_ISSUE_SKID_EN
      exp_ir = (q.size() < 2);
`else
      exp_ir = ordy | (q.size() == 0);
`endif
      chk("out_valid", 128'(OutValid), 128'(q.size() > 0));
      if (q.size() > 0) chk("out_data", 128'({Illegal, ALUCtrl, BusA, BusB}), 128'(q[0]));
      chk("in_ready", 128'(InReady), 128'(exp_ir));
      acc = iv & exp_ir;
      drn = (q.size() > 0) & ordy;
      @(posedge CLK);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(ins, ra, rb));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Reset = 1'b1;
      InValid = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      q.delete();
      #1;
      chk("rst_out_valid", 128'(OutValid), 128'(0));
      chk("rst_fields", 128'({Illegal, ALUCtrl, BusA, BusB}), 128'(0));
      chk("rst_in_ready", 128'(InReady), 128'(1));
   endtask

   task automatic send_lit(input string name, input logic [31:0] ins, input logic [31:0] ra,
                           input logic [31:0] rb, input logic [68:0] lit);
      logic acc;
      cycle(1'b1, ins, ra, rb, 1'b1, acc);
      #1;
      chk({name, "_acc"}, 128'(acc), 128'(1));
      chk({name, "_valid"}, 128'(OutValid), 128'(1));
      chk(name, 128'({Illegal, ALUCtrl, BusA, BusB}), 128'(lit));
   endtask

   function automatic logic [31:0] rand_ins();
      logic [5:0] ops [16];
      logic [5:0] fns [17];
      logic [31:0] w;
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
              6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) != 0) w[5:0]   = fns[$urandom_range(0, 16)];
      return w;
   endfunction

   initial begin
      logic        acc;
      logic [31:0] s_ins [3];
      int          k;
      logic [31:0] p_ins, p_a, p_b;

      Reset = 1'b1; InValid = 1'b0; Instruction = '0; RegA = '0; RegB = '0; OutReady = 1'b1;

      // Model pinned to hand-decoded values
      chk("m_addi",  128'(model({6'h08, 10'd0, 16'hFFFF}, 32'd5, 32'd0)),
                     128'({1'b0, 4'h2, 32'd5, 32'hFFFFFFFF}));
      chk("m_srav",  128'(model({6'h00, 15'd0, 5'd0, 6'h07}, 32'h25, 32'h80000000)),
                     128'({1'b0, 4'hD, 32'h80000000, 32'd5}));
      chk("m_lui",   128'(model({6'h0F, 10'd0, 16'h1234}, 32'h77, 32'd0)),
                     128'({1'b0, 4'hE, 32'h77, 32'h1234}));
      chk("m_bne",   128'(model({6'h05, 10'd0, 16'h0004}, 32'd9, 32'd3)),
                     128'({1'b0, 4'h6, 32'd9, 32'd3}));
      chk("m_badfn", 128'(model({6'h00, 20'd0, 6'h3C}, 32'd9, 32'd3)),
                     128'({1'b1, 4'h0, 32'd0, 32'd0}));

      do_reset();

      // Directed decode cases with literal expectations
      send_lit("addi", {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd0,
               {1'b0, 4'h2, 32'd5, 32'hFFFFFFFF});
      send_lit("sll", {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00}, 32'd0, 32'd1,
               {1'b0, 4'h3, 32'd1, 32'd4});
      send_lit("srav", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h25, 32'h80000000,
               {1'b0, 4'hD, 32'h80000000, 32'd5});
      send_lit("ori", {6'h0D, 5'd1, 5'd2, 16'h8000}, 32'h10, 32'd0,
               {1'b0, 4'h1, 32'h10, 32'h00008000});
      send_lit("lui", {6'h0F, 5'd0, 5'd2, 16'h1234}, 32'd0, 32'd0,
               {1'b0, 4'hE, 32'd0, 32'h1234});
      send_lit("illegal", {6'h3F, 26'h3FFFFFF}, 32'hDEAD, 32'hBEEF,
               {1'b1, 4'h0, 32'd0, 32'd0});
      send_lit("sw", {6'h2B, 5'd1, 5'd2, 16'h8001}, 32'h100, 32'd7,
               {1'b0, 4'h2, 32'h100, 32'hFFFF8001});

      // Three back-to-back instructions with downstream stalled for 3 cycles
      s_ins[0] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
      s_ins[1] = {6'h0C, 5'd1, 5'd2, 16'hF0F0};
      s_ins[2] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B};
      k = 0;
      for (int t = 0; t < 10; t++) begin
         cycle(k < 3, (k < 3) ? s_ins[k] : 32'd0, 32'h1000 + 32'(k), 32'h2000 + 32'(k),
               !(t >= 1 && t <= 3), acc);
         if (acc) k++;
      end
      chk("stream_all_accepted", 128'(k), 128'(3));
      chk("stream_drained", 128'(q.size()), 128'(0));

      // Reset in the middle of a stalled transfer
      for (int t = 0; t < 3; t++) cycle(1'b1, rand_ins(), $urandom, $urandom, 1'b0, acc);
      do_reset();

      // Randomized traffic; upstream holds an instruction until it is accepted
      p_ins = rand_ins(); p_a = $urandom; p_b = $urandom;
      for (int t = 0; t < 3000; t++) begin
         logic ordy;
         if ((t / 40) % 3 == 1) ordy = ($urandom_range(0, 3) == 0);
         else                   ordy = ($urandom_range(0, 3) != 0);
         cycle($urandom_range(0, 4) != 0, p_ins, p_a, p_b, ordy, acc);
         if (acc) begin p_ins = rand_ins(); p_a = $urandom; p_b = $urandom; end
         if (t == 1500) do_reset();
      end

      // Drain whatever remains
      for (int t = 0; t < 4; t++) cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
      chk("final_empty", 128'(q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
